rou_pwrbridge: RTL and testbench

//  Single-clock roubus bridge between always-on side 0 and switchable side 1.

---
 rtl/rou_pwrbridge.sv | 211 +++++++++++++++++++++
 tb/tb_rou_pwrbridge.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rou_pwrbridge.sv
// Roubus bridge between always-on side 0 and power-gated side 1: one buffered lane per
// direction plus a power sequencer that isolates side 1 and discards its traffic on power loss.

module rou_pwrbridge_lane #(
    parameter int WID   = 170,
    parameter int DEPTH = 4,
    parameter int TOUT  = 64,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push,
    input  logic [WID-1:0] din,
    input  logic           run,
    input  logic           flush,
    input  logic [2:0]     ack,
    output logic           full,
    output logic [WID-1:0] dout,
    output logic [CW:0]    drop_inc
);
    localparam int PW = $clog2(DEPTH);
    localparam int TW = $clog2(TOUT + 1);

    logic [WID-1:0] mem [DEPTH];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  cnt;
    logic           avail_q, out_valid;
    logic [TW-1:0]  tmr;
    logic           ack_ok, ack_pop, tout, pop, load, drop;

    // The head stays in the FIFO while presented; it only leaves on ack, error or timeout.
    always_comb begin
        ack_ok   = run && out_valid;
        ack_pop  = ack_ok && (ack == 3'b001 || ack == 3'b100);
        tout     = ack_ok && !ack_pop && (tmr == '0);
        pop      = ack_pop || tout;
        drop     = ack_ok && (ack == 3'b100 || tout);
        load     = run && !out_valid && avail_q && (cnt != '0);
        full     = (cnt == CW'(DEPTH));
        drop_inc = (flush ? (CW+1)'(cnt) : '0) + (CW+1)'(drop);
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            avail_q   <= 1'b0;
            out_valid <= 1'b0;
            dout      <= '0;
            tmr       <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + CW'(push) - CW'(pop);
            // Only entries that were already stored before this edge may be presented next.
            avail_q <= (cnt - CW'(pop)) != '0;
            if (pop) begin
                out_valid <= 1'b0;
                dout      <= '0;
            end else if (load) begin
                out_valid <= 1'b1;
                dout      <= mem[rd_ptr];
                tmr       <= TW'(TOUT - 1);
            end else if (ack_ok) begin
                tmr <= tmr - 1'b1;
            end
        end
    end
endmodule

// state | meaning
// OFF   | side 1 unpowered, side 0 requests answered with error
// WAKE  | power good seen, waiting out the settle window, side 0 told to retry
// ON    | both directions live
// DRAIN | power lost, 0->1 lane flushed and counted, then OFF
module rou_pwrbridge #(
    parameter int DWID     = 128,
    parameter int AWID     = 32,
    parameter int CWID     = 8,
    parameter int WID      = 2 + DWID + AWID + CWID,
    parameter int DEPTH    = 4,
    parameter int WAKE_CYC = 16,
    parameter int TOUT     = 64,
    parameter int CNTW     = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [WID-1:0]  rou0_in,
    output logic [2:0]      ack0_in,
    output logic [WID-1:0]  rou0_out,
    input  logic [2:0]      ack0_out,
    input  logic [WID-1:0]  rou1_in,
    output logic [2:0]      ack1_in,
    output logic [WID-1:0]  rou1_out,
    input  logic [2:0]      ack1_out,
    input  logic            otherside1_powered,
    output logic [1:0]      pwr_state,
    output logic            isolate,
    output logic [CNTW-1:0] drop_cnt
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int WW = $clog2(WAKE_CYC + 1);
    localparam logic [2:0] ACK_OK    = 3'b001;
    localparam logic [2:0] ACK_RETRY = 3'b010;
    localparam logic [2:0] ACK_ERR   = 3'b100;

    typedef enum logic [1:0] {OFF = 2'b00, WAKE = 2'b01, ON = 2'b10, DRAIN = 2'b11} pwr_t;

    pwr_t           state, state_nxt;
    logic [WW-1:0]  wake_cnt, wake_nxt;
    logic [2:0]     ack0_q, ack1_q;
    logic           run01, drain, req0, req1, push01, push10, full01, full10;
    logic [WID-1:0] out01;
    logic [CW:0]    inc01, inc10;
    logic [CNTW:0]  drop_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= OFF;
            wake_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wake_cnt <= wake_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wake_nxt  = wake_cnt;
        case (state)
            OFF: begin
                if (otherside1_powered) begin
                    state_nxt = WAKE;
                    wake_nxt  = WW'(WAKE_CYC - 1);
                end
            end
            WAKE: begin
                if (!otherside1_powered) state_nxt = OFF;
                else if (wake_cnt == '0) state_nxt = ON;
                else wake_nxt = wake_cnt - 1'b1;
            end
            ON:      if (!otherside1_powered) state_nxt = DRAIN;
            DRAIN:   state_nxt = OFF;
            default: state_nxt = OFF;
        endcase
    end

    // Side 1 is frozen in the cycle power drops so a late ack cannot rescue a word being flushed.
    always_comb begin
        run01    = (state == ON) && otherside1_powered;
        drain    = (state == DRAIN);
        req0     = (ack0_q == 3'b000) && (rou0_in[WID-1:WID-2] != 2'b00);
        req1     = (ack1_q == 3'b000) && (rou1_in[WID-1:WID-2] != 2'b00) && run01;
        push01   = req0 && (state == ON) && !full01;
        push10   = req1 && !full10;
        drop_sum = {1'b0, drop_cnt} + (CNTW+1)'(inc01) + (CNTW+1)'(inc10);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack0_q   <= '0;
            ack1_q   <= '0;
            drop_cnt <= '0;
        end else begin
            if (!req0) ack0_q <= '0;
            else if (state == ON) ack0_q <= full01 ? ACK_RETRY : ACK_OK;
            else if (state == WAKE) ack0_q <= ACK_RETRY;
            else ack0_q <= ACK_ERR;
            if (!req1) ack1_q <= '0;
            else ack1_q <= full10 ? ACK_RETRY : ACK_OK;
            drop_cnt <= drop_sum[CNTW] ? '1 : drop_sum[CNTW-1:0];
        end
    end

    rou_pwrbridge_lane #(.WID(WID), .DEPTH(DEPTH), .TOUT(TOUT)) u_lane01 (
        .clk      (clk),
        .rst      (rst),
        .push     (push01),
        .din      (rou0_in),
        .run      (run01),
        .flush    (drain),
        .ack      (ack1_out),
        .full     (full01),
        .dout     (out01),
        .drop_inc (inc01)
    );

    rou_pwrbridge_lane #(.WID(WID), .DEPTH(DEPTH), .TOUT(TOUT)) u_lane10 (
        .clk      (clk),
        .rst      (rst),
        .push     (push10),
        .din      (rou1_in),
        .run      (1'b1),
        .flush    (1'b0),
        .ack      (ack0_out),
        .full     (full10),
        .dout     (rou0_out),
        .drop_inc (inc10)
    );

    assign pwr_state = state;
    assign isolate   = (state != ON);
    assign ack0_in   = ack0_q;
    assign ack1_in   = isolate ? 3'b000 : ack1_q;
    assign rou1_out  = isolate ? '0 : out01;
endmodule

// File: tb/tb_rou_pwrbridge.sv
// Bench for rou_pwrbridge: directed power sequencing, timeout and drain steps, then
// random bidirectional traffic checked against per-direction reference queues.
module tb_rou_pwrbridge;
    localparam int WID   = 170;
    localparam int DEPTH = 4;
    localparam int CNTW  = 16;
    localparam int N     = 1000;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [WID-1:0]  rou0_in = '0, rou1_in = '0;
    logic [2:0]      ack0_out = '0, ack1_out = '0;
    logic            otherside1_powered = 1'b0;
    logic [2:0]      ack0_in, ack1_in;
    logic [WID-1:0]  rou0_out, rou1_out;
    logic [1:0]      pwr_state;
    logic            isolate;
    logic [CNTW-1:0] drop_cnt;

    int n_chk = 0;
    int n_fail = 0;

    rou_pwrbridge dut (
        .clk                (clk),
        .rst                (rst),
        .rou0_in            (rou0_in),
        .ack0_in            (ack0_in),
        .rou0_out           (rou0_out),
        .ack0_out           (ack0_out),
        .rou1_in            (rou1_in),
        .ack1_in            (ack1_in),
        .rou1_out           (rou1_out),
        .ack1_out           (ack1_out),
        .otherside1_powered (otherside1_powered),
        .pwr_state          (pwr_state),
        .isolate            (isolate),
        .drop_cnt           (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [WID-1:0] obs, input logic [WID-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WID-1:0] rnd_word(input logic [1:0] cmd);
        logic [191:0]   r;
        logic [WID-1:0] w;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        w = r[WID-1:0];
        w[WID-1:WID-2] = cmd;
        return w;
    endfunction

    task automatic send0(input logic [WID-1:0] w, output logic [2:0] a);
        a = 3'b000;
        rou0_in = w;
        for (int i = 0; i < 20 && a == 3'b000; i++) begin
            tick();
            a = ack0_in;
        end
        rou0_in = '0;
    endtask

    task automatic send1(input logic [WID-1:0] w, output logic [2:0] a);
        a = 3'b000;
        rou1_in = w;
        for (int i = 0; i < 20 && a == 3'b000; i++) begin
            tick();
            a = ack1_in;
        end
        rou1_in = '0;
    endtask

    task automatic wait_out1();
        for (int i = 0; i < 20 && rou1_out == '0; i++) tick();
    endtask

    initial begin
        logic [2:0]     a;
        logic [WID-1:0] aw [5];
        logic [WID-1:0] b, r, exp;
        logic [WID-1:0] cw [3];
        logic [WID-1:0] q01 [$];
        logic [WID-1:0] q10 [$];
        int wcnt, tcnt, sent0, sent1, recv01, recv10, max01, max10, cyc;

        // reset state
        repeat (3) tick();
        check("rst_state", WID'(pwr_state), WID'(2'b00));
        check("rst_drop", WID'(drop_cnt), '0);
        check("rst_rou1", rou1_out, '0);
        rst = 1'b0;
        check("rst_rou0", rou0_out, '0);
        check("rst_ack0", WID'(ack0_in), '0);
        check("rst_ack1", WID'(ack1_in), '0);
        check("off_isolate", WID'(isolate), WID'(1'b1));

        // unpowered: side 0 gets error, side 1 ignored
        rou0_in = rnd_word(2'b01);
        tick();
        check("off_ack0_err", WID'(ack0_in), WID'(3'b100));
        rou0_in = '0;
        tick();
        check("off_ack0_one_cycle", WID'(ack0_in), '0);
        check("off_rou1", rou1_out, '0);
        check("off_drop_uncounted", WID'(drop_cnt), '0);
        rou1_in = rnd_word(2'b11);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("off_ack1", WID'(ack1_in), '0);
        end
        rou1_in = '0;

        // wake window of 16 cycles, side 0 retried meanwhile
        otherside1_powered = 1'b1;
        tick();
        check("wake_enter", WID'(pwr_state), WID'(2'b01));
        wcnt = 1;
        rou0_in = rnd_word(2'b01);
        tick();
        check("wake_ack0_retry", WID'(ack0_in), WID'(3'b010));
        rou0_in = '0;
        if (pwr_state == 2'b01) wcnt++;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (pwr_state != 2'b01) break;
            wcnt++;
        end
        check("wake_len", WID'(wcnt), WID'(16));
        check("on_state", WID'(pwr_state), WID'(2'b10));
        check("on_isolate", WID'(isolate), '0);

        // fill the 0->1 lane with side 1 silent, then drain in order
        for (int i = 0; i < 5; i++) aw[i] = rnd_word(2'b01);
        send0(aw[0], a);
        check("fill_ack_0", WID'(a), WID'(3'b001));
        check("lat_n", rou1_out, '0);
        tick();
        check("lat_n1", rou1_out, '0);
        tick();
        check("lat_n2", rou1_out, aw[0]);
        for (int i = 1; i < 4; i++) begin
            send0(aw[i], a);
            check($sformatf("fill_ack_%0d", i), WID'(a), WID'(3'b001));
        end
        send0(aw[4], a);
        check("full_retry", WID'(a), WID'(3'b010));
        for (int i = 0; i < 4; i++) begin
            wait_out1();
            check($sformatf("order_a%0d", i), rou1_out, aw[i]);
            ack1_out = 3'b001;
            tick();
            ack1_out = 3'b000;
            check($sformatf("gap_a%0d", i), rou1_out, '0);
        end

        // unacked word times out after 64 presented cycles; retries do not restart the timer
        b = rnd_word(2'b10);
        send0(b, a);
        check("tout_accept", WID'(a), WID'(3'b001));
        wait_out1();
        tcnt = 0;
        while (rou1_out == b && tcnt < 200) begin
            tcnt++;
            ack1_out = tcnt[0] ? 3'b010 : 3'b000;
            tick();
        end
        ack1_out = 3'b000;
        check("tout_len", WID'(tcnt), WID'(64));
        check("tout_rou1", rou1_out, '0);
        check("tout_drop", WID'(drop_cnt), WID'(1));

        // power loss with three queued words and a queued response toward side 0
        r = rnd_word(2'b11);
        send1(r, a);
        check("rsp_accept", WID'(a), WID'(3'b001));
        for (int i = 0; i < 3; i++) begin
            cw[i] = rnd_word(2'b01);
            send0(cw[i], a);
            check($sformatf("drain_fill_%0d", i), WID'(a), WID'(3'b001));
        end
        check("drain_pre", rou1_out, cw[0]);
        otherside1_powered = 1'b0;
        ack1_out = 3'b001;
        tick();
        ack1_out = 3'b000;
        check("drain_state", WID'(pwr_state), WID'(2'b11));
        check("drain_isolate", WID'(isolate), WID'(1'b1));
        check("drain_rou1", rou1_out, '0);
        check("drain_drop_pre", WID'(drop_cnt), WID'(1));
        tick();
        check("drain_off", WID'(pwr_state), WID'(2'b00));
        check("drain_drop", WID'(drop_cnt), WID'(4));
        check("rsp_delivered", rou0_out, r);
        ack0_out = 3'b001;
        tick();
        ack0_out = 3'b000;
        check("rsp_popped", rou0_out, '0);

        // power back up, then random traffic both ways at full rate
        otherside1_powered = 1'b1;
        for (int i = 0; i < 40 && pwr_state != 2'b10; i++) tick();
        check("repower_on", WID'(pwr_state), WID'(2'b10));

        sent0 = 0; sent1 = 0; recv01 = 0; recv10 = 0; max01 = 0; max10 = 0; cyc = 0;
        rou0_in = rnd_word(2'($urandom_range(1, 3)));
        rou1_in = rnd_word(2'($urandom_range(1, 3)));
        while ((recv01 < N || recv10 < N) && cyc < 30000) begin
            tick();
            cyc++;
            if (ack0_in != 3'b000) begin
                check("rnd_ack0", WID'(ack0_in == 3'b001 || ack0_in == 3'b010), WID'(1'b1));
                if (ack0_in == 3'b001) begin
                    q01.push_back(rou0_in);
                    sent0++;
                    rou0_in = (sent0 < N) ? rnd_word(2'($urandom_range(1, 3))) : '0;
                end
            end
            if (ack1_in != 3'b000) begin
                check("rnd_ack1", WID'(ack1_in == 3'b001 || ack1_in == 3'b010), WID'(1'b1));
                if (ack1_in == 3'b001) begin
                    q10.push_back(rou1_in);
                    sent1++;
                    rou1_in = (sent1 < N) ? rnd_word(2'($urandom_range(1, 3))) : '0;
                end
            end
            if (q01.size() > max01) max01 = q01.size();
            if (q10.size() > max10) max10 = q10.size();
            if (rou1_out != '0) begin
                if ($urandom_range(0, 1) == 1) begin
                    exp = '0;
                    if (q01.size() > 0) exp = q01.pop_front();
                    check("rnd_order01", rou1_out, exp);
                    recv01++;
                    ack1_out = 3'b001;
                end else begin
                    ack1_out = 3'b010;
                end
            end else begin
                ack1_out = 3'($urandom_range(0, 2));
            end
            if (rou0_out != '0) begin
                if ($urandom_range(0, 1) == 1) begin
                    exp = '0;
                    if (q10.size() > 0) exp = q10.pop_front();
                    check("rnd_order10", rou0_out, exp);
                    recv10++;
                    ack0_out = 3'b001;
                end else begin
                    ack0_out = 3'b010;
                end
            end else begin
                ack0_out = 3'($urandom_range(0, 2));
            end
        end
        rou0_in = '0;
        rou1_in = '0;
        ack0_out = 3'b000;
        ack1_out = 3'b000;
        tick();
        check("rnd_recv01", WID'(recv01), WID'(N));
        check("rnd_recv10", WID'(recv10), WID'(N));
        check("rnd_left01", WID'(q01.size()), '0);
        check("rnd_left10", WID'(q10.size()), '0);
        check("rnd_occ01", WID'(max01 <= DEPTH), WID'(1'b1));
        check("rnd_occ10", WID'(max10 <= DEPTH), WID'(1'b1));
        check("rnd_no_drop", WID'(drop_cnt), WID'(4));

        // reset with a word in flight
        b = rnd_word(2'b01);
        send0(b, a);
        check("mid_accept", WID'(a), WID'(3'b001));
        wait_out1();
        check("mid_present", rou1_out, b);
        rst = 1'b1;
        tick();
        check("mid_rst_rou1", rou1_out, '0);
        check("mid_rst_state", WID'(pwr_state), WID'(2'b00));
        check("mid_rst_drop", WID'(drop_cnt), '0);
        rst = 1'b0;
        tick();
        check("mid_rst_wake", WID'(pwr_state), WID'(2'b01));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
